// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Holds the PC, issues word reads to a
// synchronous, always-ready instruction memory, buffers each returned word
// together with its PC in a small FIFO, and presents the FIFO head to the
// decoder over a valid/ready handshake. A redirect loads a new PC and squashes
// everything buffered or still in flight.
//
// Ports:
//   clk             system clock, all state on posedge
//   rst_n           asynchronous active-low reset
//   fetch_en        allows new memory requests while high
//   imem_req        read request this cycle
//   imem_addr       word-aligned byte address of the request (always = pc)
//   imem_rdata      read data, valid the cycle after imem_req
//   redirect_valid  load redirect_pc and flush the pipeline
//   redirect_pc     redirect target; bits [1:0] are ignored
//   inst_valid      FIFO head valid
//   inst_ready      decoder accepts the head
//   inst_data       instruction word at the head (0 when empty)
//   inst_pc         PC of the head instruction (0 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            inflight;
    logic            squash;
    logic [31:0]     tag;

    logic [31:0]     fifo_data [DEPTH];
    logic [31:0]     fifo_pc   [DEPTH];

    logic            pop;
    logic            push;
    logic [CW:0]     occupancy;

    // Only the low two bits of the redirect target are discarded.
    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;

    // A response is kept only if no redirect is squashing it: either in the
    // cycle it arrives, or (squash) because a redirect happened the cycle
    // before and the slot belongs to the old stream.
    assign push = inflight & ~squash & ~redirect_valid;

    // Slots the FIFO will need once the in-flight word lands, crediting the
    // entry leaving this cycle so a full FIFO still streams 1 word/cycle.
    // pop implies count >= 1, so this never underflows.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

    assign imem_req  = (state == RUN) && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc;

    assign inst_data = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc   = inst_valid ? fifo_pc[rd_ptr]   : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= {RESET_PC[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
            tag      <= '0;
        end else begin
            state    <= fetch_en ? RUN : IDLE;
            inflight <= imem_req;
            squash   <= redirect_valid;
            if (imem_req) begin
                tag <= pc;
            end

            if (redirect_valid) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (imem_req) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; an entry is only
    // read once count says it was written, and the outputs are zeroed when
    // the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A queue-based reference model predicts
// requests, addresses and the delivered instruction stream every cycle, and a
// set of directed scenarios pins the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // Second instance used only to observe PC wrap from a high reset PC.
    logic        w_req;
    logic [31:0] w_addr_o;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [31:0] w_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (1'b1),
        .imem_req       (w_req),
        .imem_addr      (w_addr_o),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (w_valid),
        .inst_ready     (1'b1),
        .inst_data      (w_data),
        .inst_pc        (w_pc)
    );

    // Instruction memories: word = address ^ KEY one cycle after a request,
    // garbage otherwise so that stray captures are visible.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ KEY) : $urandom;
        w_rdata    <= w_req ? (w_addr_o ^ KEY) : $urandom;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // First three request addresses of the wrap instance.
    logic [31:0] w_seen [3];
    int          w_n = 0;
    always @(posedge clk) begin
        if (rst_n && w_req && w_n < 3) begin
            w_seen[w_n] = w_addr_o;
            w_n++;
        end
    end

    // PCs the decoder actually accepted from the main DUT.
    logic [31:0] deliv [$];
    always @(posedge clk) begin
        if (rst_n && inst_valid && inst_ready) deliv.push_back(inst_pc);
    end

    // ---------------- reference model ----------------
    // m_run: fetch_en seen at the previous edge; m_q: PCs of buffered words in
    // order; m_infl/m_infl_addr: the request whose data arrives next cycle.
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_addr;
    logic [31:0] m_q [$];

    task automatic model_reset();
        m_run  = 1'b0;
        m_pc   = 32'h0;
        m_infl = 1'b0;
        m_q.delete();
    endtask

    initial begin : compare
        bit exp_valid;
        bit exp_req;
        bit pop;
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("rst_req",   imem_req,   0);
                check("rst_addr",  imem_addr,  32'h0);
                check("rst_valid", inst_valid, 0);
                check("rst_data",  inst_data,  32'h0);
                check("rst_pc",    inst_pc,    32'h0);
            end else begin
                exp_valid = (m_q.size() > 0);
                pop       = exp_valid && inst_ready;
                exp_req   = m_run && !redirect_valid &&
                            (m_q.size() + int'(m_infl) - int'(pop) < DEPTH);
                check("req",   imem_req,   exp_req);
                check("addr",  imem_addr,  m_pc);
                check("valid", inst_valid, exp_valid);
                if (exp_valid) begin
                    check("inst_pc",   inst_pc,   m_q[0]);
                    check("inst_data", inst_data, m_q[0] ^ KEY);
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                pop     = (m_q.size() > 0) && inst_ready;
                exp_req = m_run && !redirect_valid &&
                          (m_q.size() + int'(m_infl) - int'(pop) < DEPTH);
                if (pop) void'(m_q.pop_front());
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc   = {redirect_pc[31:2], 2'b00};
                    m_infl = 1'b0;
                end else begin
                    if (m_infl) m_q.push_back(m_infl_addr);
                    m_infl = exp_req;
                    if (exp_req) begin
                        m_infl_addr = m_pc;
                        m_pc        = m_pc + 32'd4;
                    end
                end
                m_run = fetch_en;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset(input bit rdy);
        @(negedge clk);
        rst_n = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; fetch_en = 1'b1; inst_ready = rdy;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [31:0] d0, d1;
        int          old_cnt;

        // Reset values.
        @(negedge clk); #3;
        check("t0_req",   imem_req,   0);
        check("t0_addr",  imem_addr,  32'h0);
        check("t0_valid", inst_valid, 0);
        check("t0_data",  inst_data,  32'h0);
        check("t0_pc",    inst_pc,    32'h0);

        // Streaming: first word valid 2 cycles after first request.
        do_reset(1'b1);
        @(negedge clk); #3; check("s_req0", imem_req, 1); check("s_addr0", imem_addr, 32'h0);
        @(negedge clk); #3; check("s_addr1", imem_addr, 32'h4); check("s_valid1", inst_valid, 0);
        @(negedge clk); #3;
        check("s_addr2", imem_addr, 32'h8);
        check("s_valid2", inst_valid, 1);
        check("s_pc2", inst_pc, 32'h0);
        check("s_data2", inst_data, 32'hA5A5_0000);
        @(negedge clk); #3; check("s_pc3", inst_pc, 32'h4);

        // Backpressure: exactly DEPTH requests, then drain and resume.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            check("bp_req", imem_req, 1);
            check("bp_addr", imem_addr, 32'(i * 4));
        end
        @(negedge clk); #3; check("bp_stop5", imem_req, 0);
        @(negedge clk); #3;
        check("bp_stop6", imem_req, 0);
        check("bp_hold_pc", inst_pc, 32'h0);
        check("bp_full_valid", inst_valid, 1);
        @(negedge clk); inst_ready = 1'b1; #3;
        check("bp_resume_req", imem_req, 1);
        check("bp_resume_addr", imem_addr, 32'h10);
        check("bp_drain0", inst_pc, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #3;
            check("bp_drain", inst_pc, 32'(i * 4));
        end

        // Redirect with one queued and one in flight.
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #3;
        check("rd_req_r", imem_req, 0);
        @(negedge clk); redirect_valid = 1'b0; #3;
        check("rd_req_r1", imem_req, 1);
        check("rd_addr_r1", imem_addr, 32'h0000_0100);
        check("rd_valid_r1", inst_valid, 0);
        @(negedge clk); #3; check("rd_valid_r2", inst_valid, 0);
        @(negedge clk); #3;
        check("rd_valid_r3", inst_valid, 1);
        check("rd_pc_r3", inst_pc, 32'h0000_0100);
        check("rd_data_r3", inst_data, 32'hA5A5_0100);

        // Redirect in the same cycle as a handshake.
        do_reset(1'b0);
        deliv.delete();
        repeat (2) @(negedge clk);
        @(negedge clk); inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk); redirect_valid = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        d0 = (deliv.size() > 0) ? deliv[0] : 32'hDEAD_BEEF;
        d1 = (deliv.size() > 1) ? deliv[1] : 32'hDEAD_BEEF;
        old_cnt = 0;
        foreach (deliv[i]) if (deliv[i] < 32'h200) old_cnt++;
        check("hs_first", d0, 32'h0);
        check("hs_second", d1, 32'h200);
        check("hs_old_count", 32'(old_cnt), 32'd1);
        check("hs_total", 32'(deliv.size()), 32'd4);

        // PC wrap from RESET_PC = FFFF_FFF8.
        check("wrap_n", 32'(w_n), 32'd3);
        check("wrap_a0", w_seen[0], 32'hFFFF_FFF8);
        check("wrap_a1", w_seen[1], 32'hFFFF_FFFC);
        check("wrap_a2", w_seen[2], 32'h0000_0000);

        // Randomised traffic against the model.
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
        end

        // Asynchronous reset with a request in flight.
        @(negedge clk);
        fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        check("ar_pre_req", imem_req, 1);
        check("ar_pre_valid", inst_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_valid", inst_valid, 0);
        check("ar_addr", imem_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #3;
        check("ar_rest_req", imem_req, 1);
        check("ar_rest_addr", imem_addr, 32'h0);
        check("ar_rest_valid", inst_valid, 0);
        @(negedge clk); #3; check("ar_rest_valid1", inst_valid, 0);
        @(negedge clk); #3;
        check("ar_rest_pc", inst_pc, 32'h0);
        check("ar_rest_data", inst_data, 32'hA5A5_0000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
